// File: rtl/mux_pkg.sv
// Shared definitions for the 4-channel mux control path: channel indices,
// select width and the arbiter FSM state type.
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH_A = 2'd0;
    localparam logic [SEL_W-1:0] CH_B = 2'd1;
    localparam logic [SEL_W-1:0] CH_C = 2'd2;
    localparam logic [SEL_W-1:0] CH_D = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // One-hot decode of a channel index.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
        logic [NUM_CH-1:0] oh;
        oh     = '0;
        oh[ch] = 1'b1;
        return oh;
    endfunction

endpackage : mux_pkg

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request after 'last',
// wrapping around so that 'last' itself has the lowest priority.
module rr_pick4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    logic [SEL_W-1:0]  cand [NUM_CH];
    logic [NUM_CH-1:0] hit;

    // cand[k] is the channel sitting k+1 positions after 'last'.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
        assign cand[gi] = last + SEL_W'(gi + 1);
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        idx = last;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

    assign any = |req;

endmodule : rr_pick4

// File: rtl/rr_sel_arbiter_4ch.sv
// Round-robin, burst-limited arbiter for four valid/ready sources that
// steers the 4-to-1 mux select and presents one output handshake.
module rr_sel_arbiter_4ch
    import mux_pkg::*;
#(
    parameter  int MAX_BURST = 4,
    localparam int CNT_W     = $clog2(MAX_BURST) + 1
)(
    input  logic              clk,
    input  logic              reset_L,
    input  logic [NUM_CH-1:0] req_valid,
    output logic [NUM_CH-1:0] req_ready,
    output logic [SEL_W-1:0]  sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_e            state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  last_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic              in_grant;
    logic              cur_valid;
    logic              xfer;

    rr_pick4 u_pick (
        .req  (req_valid),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign in_grant  = (state_q == ST_GRANT);
    assign cur_valid = req_valid[sel_q];
    assign xfer      = in_grant & cur_valid & out_ready;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            sel_q   <= CH_A;
            last_q  <= CH_D;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        sel_q   <= pick_idx;
                        cnt_q   <= '0;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // A transfer wins over the idle-channel exit; both leave via IDLE.
                    if (xfer) begin
                        if (cnt_q == CNT_LAST) begin
                            last_q  <= sel_q;
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (!cur_valid) begin
                        last_q  <= sel_q;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
        assign req_ready[gi] = in_grant & out_ready & (sel_q == SEL_W'(gi));
    end

    assign sel       = sel_q;
    assign out_valid = in_grant & cur_valid;
    assign busy      = in_grant;

endmodule : rr_sel_arbiter_4ch

// File: tb/tb_rr_sel_arbiter_4ch.sv
// Randomised bench for rr_sel_arbiter_4ch: three instances (MAX_BURST 1, 2, 4)
// compared every cycle against a transaction-level round-robin model.
module tb_rr_sel_arbiter_4ch;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [3:0] rv   [NI];
    logic       ordy [NI];
    logic [3:0] rr   [NI];
    logic [1:0] sl   [NI];
    logic       ov   [NI];
    logic       bz   [NI];

    int mb [NI] = '{1, 2, 4};

    // Model state: whether a channel is granted, which one, the channel that
    // last held the grant, and how many words it has moved in this burst.
    int         m_grant [NI];
    int         m_ch    [NI];
    int         m_last  [NI];
    int         m_done  [NI];
    logic [3:0] m_xf    [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_sel_arbiter_4ch #(.MAX_BURST(1)) u_mb1 (
        .clk(clk), .reset_L(reset_L), .req_valid(rv[0]), .req_ready(rr[0]),
        .sel(sl[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bz[0]));
    rr_sel_arbiter_4ch #(.MAX_BURST(2)) u_mb2 (
        .clk(clk), .reset_L(reset_L), .req_valid(rv[1]), .req_ready(rr[1]),
        .sel(sl[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bz[1]));
    rr_sel_arbiter_4ch #(.MAX_BURST(4)) u_mb4 (
        .clk(clk), .reset_L(reset_L), .req_valid(rv[2]), .req_ready(rr[2]),
        .sel(sl[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .busy(bz[2]));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_grant[i] = 0;
            m_ch[i]    = 0;
            m_last[i]  = 3;
            m_done[i]  = 0;
            m_xf[i]    = 4'b0000;
        end
    endtask

    task automatic check_reset_outputs(input string when);
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("%s mb%0d sel", when, mb[i]), 32'(sl[i]), 32'd0);
            check_val($sformatf("%s mb%0d out_valid", when, mb[i]), 32'(ov[i]), 32'd0);
            check_val($sformatf("%s mb%0d req_ready", when, mb[i]), 32'(rr[i]), 32'd0);
            check_val($sformatf("%s mb%0d busy", when, mb[i]), 32'(bz[i]), 32'd0);
        end
    endtask

    task automatic compare_all(input int cyc);
        logic [3:0] e_rdy;
        logic       e_ov;
        for (int i = 0; i < NI; i++) begin
            e_rdy = 4'b0000;
            e_ov  = 1'b0;
            if (m_grant[i] != 0) begin
                e_ov = rv[i][m_ch[i]];
                if (ordy[i]) e_rdy = 4'(1 << m_ch[i]);
            end
            check_val($sformatf("c%0d mb%0d sel", cyc, mb[i]), 32'(sl[i]), 32'(m_ch[i]));
            check_val($sformatf("c%0d mb%0d busy", cyc, mb[i]), 32'(bz[i]), 32'(m_grant[i] != 0));
            check_val($sformatf("c%0d mb%0d out_valid", cyc, mb[i]), 32'(ov[i]), 32'(e_ov));
            check_val($sformatf("c%0d mb%0d req_ready", cyc, mb[i]), 32'(rr[i]), 32'(e_rdy));
        end
    endtask

    // Advance the model by one clock using the inputs of the cycle just ended.
    task automatic model_step(input bit verbose, input int cyc);
        int c;
        for (int i = 0; i < NI; i++) begin
            m_xf[i] = 4'b0000;
            if (m_grant[i] == 0) begin
                for (int k = 1; k <= 4; k++) begin
                    c = (m_last[i] + k) % 4;
                    if (m_grant[i] == 0 && rv[i][c]) begin
                        m_grant[i] = 1;
                        m_ch[i]    = c;
                        m_done[i]  = 0;
                    end
                end
            end else if (rv[i][m_ch[i]] && ordy[i]) begin
                m_xf[i][m_ch[i]] = 1'b1;
                m_done[i]++;
                if (verbose)
                    $display("[TB] c%0d mb%0d transfer ch%0d word %0d", cyc, mb[i], m_ch[i], m_done[i]);
                if (m_done[i] == mb[i]) begin
                    m_last[i]  = m_ch[i];
                    m_grant[i] = 0;
                end
            end else if (!rv[i][m_ch[i]]) begin
                m_last[i]  = m_ch[i];
                m_grant[i] = 0;
            end
        end
    endtask

    // mode 0: all channels requesting with periodic stalls
    // mode 1: only channel c requesting
    // mode 2: random sources that hold valid until accepted
    task automatic drive(input int mode, input int cyc);
        for (int i = 0; i < NI; i++) begin
            case (mode)
                0: begin
                    rv[i]   = 4'b1111;
                    ordy[i] = !((cyc % 16) >= 9 && (cyc % 16) <= 11);
                end
                1: begin
                    rv[i]   = 4'b0100;
                    ordy[i] = 1'b1;
                end
                default: begin
                    for (int b = 0; b < 4; b++) begin
                        if (m_xf[i][b])
                            rv[i][b] = 1'($urandom_range(0, 1));
                        else if (!rv[i][b])
                            rv[i][b] = ($urandom_range(0, 9) < 3);
                    end
                    ordy[i] = ($urandom_range(0, 9) < 7);
                end
            endcase
        end
    endtask

    task automatic run_cycles(input int mode, input int n, input bit verbose);
        for (int cyc = 0; cyc < n; cyc++) begin
            @(negedge clk);
            compare_all(cyc);
            @(posedge clk);
            model_step(verbose, cyc);
            #1;
            drive(mode, cyc + 1);
        end
    endtask

    initial begin
        reset_L = 1'b0;
        for (int i = 0; i < NI; i++) begin
            rv[i]   = 4'b1111;
            ordy[i] = 1'b1;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset_L = 1'b1;

        $display("[TB] phase: all channels requesting");
        run_cycles(0, 40, 1'b1);
        $display("[TB] phase: single requester on channel c");
        run_cycles(1, 30, 1'b1);
        $display("[TB] phase: random sources");
        run_cycles(2, 500, 1'b0);

        $display("[TB] phase: reset asserted mid-grant");
        drive(0, 0);
        run_cycles(0, 3, 1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async");
        @(posedge clk);
        #1;
        check_reset_outputs("held");
        reset_L = 1'b1;
        run_cycles(0, 10, 1'b1);
        run_cycles(2, 200, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rr_sel_arbiter_4ch
